// File: rtl/riscv_regfile_scoreboard_pkg.sv
// Shared constants and address helpers for the register file with busy scoreboard.
//
// A register address is ADDR_WIDTH bits wide. Its top bit selects the FP bank and
// the remaining ADDR_WIDTH-1 bits index a word inside the bank. In an FPU-less
// configuration the bank bit is ignored and only the integer bank exists.
//
// Contents:
//   NUM_WORDS / NUM_TOT / CNT_WIDTH : constants for the default 6-bit, two-bank build
//   num_words / num_tot / cnt_width : the same quantities for any parameterisation
//   reg_flat                        : bank/index of a register, packed as bank*NUM_WORDS+index
package riscv_regfile_scoreboard_pkg;

    localparam int ADDR_WIDTH_DEF = 6;
    localparam int NUM_WORDS      = 2 ** (ADDR_WIDTH_DEF - 1);
    localparam int NUM_TOT        = 2 * NUM_WORDS;
    localparam int CNT_WIDTH      = $clog2(NUM_TOT + 1);

    function automatic int num_words(input int aw);
        return 2 ** (aw - 1);
    endfunction

    function automatic int num_tot(input int aw, input int fpu);
        return (fpu != 0) ? 2 * num_words(aw) : num_words(aw);
    endfunction

    function automatic int cnt_width(input int aw, input int fpu);
        return $clog2(num_tot(aw, fpu) + 1);
    endfunction

    // Bank and in-bank index folded into one storage index. Without an FP bank
    // the bank bit is dropped, so FP addresses alias the integer registers.
    function automatic int reg_flat(input int addr, input int aw, input int fpu);
        int nw;
        int idx;
        int bank;
        nw   = num_words(aw);
        idx  = addr & (nw - 1);
        bank = (fpu != 0) ? ((addr >> (aw - 1)) & 1) : 0;
        return bank * nw + idx;
    endfunction

endpackage

// File: rtl/riscv_regfile_scoreboard_wr_arbiter.sv
// Per-register write decode for one bank of the register file.
//
// For every word of the bank, reports whether some enabled write port targets it
// and which data wins. Ports are scanned in ascending order so the
// highest-indexed enabled port overrides lower ones on a collision.
//
// Ports:
//   waddr   : write addresses, one per port
//   wdata   : write data, one per port
//   we      : write enables, one per port
//   wr_en   : per-word "written this cycle"
//   wr_data : per-word winning write data
module riscv_regfile_wr_arbiter
    import riscv_regfile_scoreboard_pkg::*;
#(
    parameter int   ADDR_WIDTH = 6,
    parameter int   DATA_WIDTH = 32,
    parameter int   NR_WPORTS  = 2,
    parameter int   FPU        = 0,
    parameter logic BANK       = 1'b0,
    parameter bit   HARD_ZERO  = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0]                                 waddr [NR_WPORTS],
    input  logic [DATA_WIDTH-1:0]                                 wdata [NR_WPORTS],
    input  logic [NR_WPORTS-1:0]                                  we,
    output logic [num_words(ADDR_WIDTH)-1:0]                      wr_en,
    output logic [num_words(ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]      wr_data
);

    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int p = 0; p < NR_WPORTS; p++) begin
            if (we[p] && ((FPU == 0) || (waddr[p][ADDR_WIDTH-1] == BANK))) begin
                wr_en[waddr[p][ADDR_WIDTH-2:0]]   = 1'b1;
                wr_data[waddr[p][ADDR_WIDTH-2:0]] = wdata[p];
            end
        end
        // Integer x0 is hardwired to zero: it is never written.
        if (HARD_ZERO) begin
            wr_en[0]   = 1'b0;
            wr_data[0] = '0;
        end
    end

endmodule

// File: rtl/riscv_regfile_scoreboard.sv
// Multi-ported RISC-V register file with a busy-bit scoreboard.
//
// Reads are combinational. Writes commit at the rising edge; with BYPASS set a
// read that matches a same-cycle write sees the write data. A long-latency
// instruction reserves its destination through the rsv handshake; the register
// stays busy until a write to it arrives or flush_i clears every reservation.
//
// Reservation handshake: rsv_ready_o depends only on registered busy state and
// flush_i; a reservation is taken on a rising edge where rsv_valid_i and
// rsv_ready_o are both high. Reserving integer x0 is always ready and does nothing.
//
// Ports:
//   clk, rst_n               : clock (rising edge), asynchronous active-low reset
//   raddr_i / rdata_o        : read ports
//   rbusy_o                  : per read port, addressed register has a pending write
//   waddr_i / wdata_i / we_i : write ports, highest index wins on collision
//   rsv_valid_i / rsv_addr_i / rsv_ready_o : reservation handshake
//   flush_i                  : drop all reservations (data untouched)
//   busy_cnt_o               : number of busy registers
module riscv_regfile_scoreboard
    import riscv_regfile_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int NR_RPORTS  = 3,
    parameter int NR_WPORTS  = 2,
    parameter int BYPASS     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_WIDTH-1:0]                 raddr_i [NR_RPORTS],
    output logic [DATA_WIDTH-1:0]                 rdata_o [NR_RPORTS],
    output logic [NR_RPORTS-1:0]                  rbusy_o,
    input  logic [ADDR_WIDTH-1:0]                 waddr_i [NR_WPORTS],
    input  logic [DATA_WIDTH-1:0]                 wdata_i [NR_WPORTS],
    input  logic [NR_WPORTS-1:0]                  we_i,
    input  logic                                  rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]                 rsv_addr_i,
    output logic                                  rsv_ready_o,
    input  logic                                  flush_i,
    output logic [cnt_width(ADDR_WIDTH, FPU)-1:0] busy_cnt_o
);

    localparam int NW = num_words(ADDR_WIDTH);
    localparam int NB = (FPU != 0) ? 2 : 1;
    localparam int NT = NB * NW;
    localparam int FW = (FPU != 0) ? ADDR_WIDTH : ADDR_WIDTH - 1;
    localparam int CW = cnt_width(ADDR_WIDTH, FPU);

    function automatic logic [FW-1:0] flat(input logic [ADDR_WIDTH-1:0] a);
        return FW'(reg_flat(int'(a), ADDR_WIDTH, FPU));
    endfunction

    logic [DATA_WIDTH-1:0] regs [NT];
    logic [NT-1:0]         busy;
    logic [NT-1:0]         busy_n;
    logic [CW-1:0]         busy_cnt;
    logic [CW-1:0]         cnt_n;
    logic [CW-1:0]         rel_cnt;

    // Bank-major packing makes the per-bank decode line up with the flat index.
    logic [NB-1:0][NW-1:0]                 bank_wen;
    logic [NB-1:0][NW-1:0][DATA_WIDTH-1:0] bank_wdata;
    logic [NT-1:0]                         wen;
    logic [NT-1:0][DATA_WIDTH-1:0]         wdat;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        riscv_regfile_wr_arbiter #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .NR_WPORTS  (NR_WPORTS),
            .FPU        (FPU),
            .BANK       (1'(b)),
            .HARD_ZERO  (b == 0)
        ) u_arb (
            .waddr   (waddr_i),
            .wdata   (wdata_i),
            .we      (we_i),
            .wr_en   (bank_wen[b]),
            .wr_data (bank_wdata[b])
        );
    end

    assign wen  = bank_wen;
    assign wdat = bank_wdata;

    logic [FW-1:0] rsv_idx;
    logic          rsv_is_x0;
    logic          rsv_accept;

    assign rsv_idx     = flat(rsv_addr_i);
    assign rsv_is_x0   = (rsv_idx == '0);
    assign rsv_ready_o = rsv_is_x0 || (!busy[rsv_idx] && !flush_i);
    assign rsv_accept  = rsv_valid_i && rsv_ready_o && !rsv_is_x0;

    // An accepted reservation never targets a busy register, so a same-cycle
    // write to it releases nothing and the new reservation survives.
    always_comb begin
        busy_n  = busy & ~wen;
        rel_cnt = '0;
        for (int i = 0; i < NT; i++) begin
            if (busy[i] && wen[i]) begin
                rel_cnt = rel_cnt + CW'(1);
            end
        end
        if (rsv_accept) begin
            busy_n[rsv_idx] = 1'b1;
        end
        cnt_n = busy_cnt + CW'(rsv_accept) - rel_cnt;
        if (flush_i) begin
            busy_n = '0;
            cnt_n  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) begin
                regs[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int i = 0; i < NT; i++) begin
                if (wen[i]) begin
                    regs[i] <= wdat[i];
                end
            end
            busy     <= busy_n;
            busy_cnt <= cnt_n;
        end
    end

    assign busy_cnt_o = busy_cnt;

    // Outputs are forced low during reset so a forwarded write cannot leak out.
    for (genvar p = 0; p < NR_RPORTS; p++) begin : g_rd
        logic [FW-1:0] ri;
        logic          fwd;
        assign ri         = flat(raddr_i[p]);
        assign fwd        = (BYPASS != 0) && wen[ri];
        assign rdata_o[p] = !rst_n ? '0 : (fwd ? wdat[ri] : regs[ri]);
        assign rbusy_o[p] = rst_n && busy[ri] && !fwd;
    end

endmodule

// File: doc/riscv_regfile_scoreboard.md
RISCV_REGFILE_SCOREBOARD -- requirements
Module: riscv_regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, full register address width; bit ADDR_WIDTH-1 is the FP-bank select.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, register width.
REQ-003 The block SHALL have parameter FPU, default 0; when 1, an FP bank of 2**(ADDR_WIDTH-1) words exists; when 0, the bank-select bit is ignored.
REQ-004 The block SHALL have parameter NR_RPORTS, default 3, number of read ports (1..4).
REQ-005 The block SHALL have parameter NR_WPORTS, default 2, number of write ports (1..3).
REQ-006 The block SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding in the same cycle.
REQ-007 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port raddr_i, input, NR_RPORTS x ADDR_WIDTH: read addresses.
REQ-010 The block SHALL have port rdata_o, output, NR_RPORTS x DATA_WIDTH: read data.
REQ-011 The block SHALL have port rbusy_o, output, NR_RPORTS: the addressed register has a pending reserved write.
REQ-012 The block SHALL have ports waddr_i, wdata_i and we_i, inputs, NR_WPORTS x (ADDR_WIDTH / DATA_WIDTH / 1): write ports.
REQ-013 The block SHALL have ports rsv_valid_i (input, 1), rsv_addr_i (input, ADDR_WIDTH) and rsv_ready_o (output, 1): reservation handshake for long-latency writebacks.
REQ-014 The block SHALL have port flush_i, input, 1 bit: clears all reservations.
REQ-015 The block SHALL have port busy_cnt_o, output, clog2(NUM_TOT+1) bits: number of currently reserved registers.

Function
REQ-016 Integer register 0 SHALL always read 0, SHALL never be written, and SHALL never be busy; FP register 0 SHALL be a normal register.
REQ-017 Reads SHALL be combinational; with BYPASS=0, a read returns the pre-edge contents.
REQ-018 With BYPASS=1, a read matching an enabled write address SHALL return that port's wdata_i, and rbusy_o SHALL reflect the post-release value.
REQ-019 A write SHALL take effect at the rising edge; when ports collide on one address, the highest-indexed enabled port SHALL win (data and bypass).
REQ-020 rsv_ready_o SHALL equal !busy[rsv_addr_i] && !flush_i, using registered state only; a reservation of integer register 0 SHALL always be ready and have no effect.
REQ-021 A reservation SHALL be accepted when rsv_valid_i && rsv_ready_o, setting busy[rsv_addr_i] at the next edge.
REQ-022 An enabled write to a busy register SHALL clear its busy bit at the edge; writes to non-busy registers SHALL be allowed.
REQ-023 When a write and an accepted reservation target the same register in the same cycle, the register SHALL end busy (the reservation belongs to a newer instruction) and the write data SHALL still commit.
REQ-024 flush_i SHALL clear all busy bits at the edge, override the same-cycle reservation, and leave register contents unaffected; same-cycle writes SHALL still commit.
REQ-025 busy_cnt_o SHALL be a registered counter, updated as +accept -releases -flush(to 0), and SHALL equal popcount(busy) at every cycle.

Reset
REQ-026 While rst_n=0, all registers, all busy bits and busy_cnt_o SHALL be 0 asynchronously, rdata_o SHALL be 0, and rbusy_o SHALL be 0.
REQ-027 A reservation or write coincident with reset deassertion SHALL follow normal rules from the first rising edge with rst_n=1.

Structure
REQ-028 A shared package SHALL hold the constants NUM_WORDS, NUM_TOT and CNT_WIDTH, and a function returning a register's bank/index.
REQ-029 A single sub-module, riscv_regfile_wr_arbiter, SHALL perform per-register write decode and priority select, instanced once per bank.
REQ-030 Register and busy storage SHALL be flip-flops with the asynchronous reset.

Verification
REQ-031 The bench SHALL cover: write x5=0xDEADBEEF on port 0, then read x5 on all ports -> 0xDEADBEEF; write x0=0x1 -> x0 reads 0.
REQ-032 The bench SHALL cover: port 0 and port 1 both write x7 (0x11 / 0x22) -> x7=0x22; with BYPASS=1, the same-cycle read of x7 returns 0x22.
REQ-033 The bench SHALL cover: reserve x9 -> rbusy=1, busy_cnt=1, and a re-reserve of x9 sees rsv_ready_o=0; a write to x9 -> busy clears and busy_cnt=0.
REQ-034 The bench SHALL cover: a same-cycle write to x9 and reservation of x9 -> x9 updated, still busy, busy_cnt=1.
REQ-035 The bench SHALL cover: reserve x3, x4 and f2 (FPU=1), then flush plus a reservation of x6 in one cycle -> busy_cnt=0, x6 not busy, register data intact.
REQ-036 The bench SHALL cover: asserting rst_n low mid-sequence -> all registers read 0 and busy_cnt=0 immediately, without a clock edge.
